// File: rtl/cbfp_scaler.sv
// cbfp_scaler: block-floating-point normalisation after the radix-2 butterfly.
// Captures one block into a ping-pong bank, tracks the minimum redundant-sign-bit
// count across the block, then replays it shifted, rounded and saturated.
module cbfp_scaler #(
    parameter int unsigned IN_WIDTH  = 23,
    parameter int unsigned OUT_WIDTH = 11,
    parameter int unsigned NUM       = 16,
    parameter int unsigned BLK_CYC   = 4,
    parameter int unsigned EXP_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        valid_in,
    input  logic signed [IN_WIDTH-1:0]  din1_re  [0:NUM-1],
    input  logic signed [IN_WIDTH-1:0]  din1_im  [0:NUM-1],
    input  logic signed [IN_WIDTH-1:0]  din2_re  [0:NUM-1],
    input  logic signed [IN_WIDTH-1:0]  din2_im  [0:NUM-1],
    output logic signed [OUT_WIDTH-1:0] dout1_re [0:NUM-1],
    output logic signed [OUT_WIDTH-1:0] dout1_im [0:NUM-1],
    output logic signed [OUT_WIDTH-1:0] dout2_re [0:NUM-1],
    output logic signed [OUT_WIDTH-1:0] dout2_im [0:NUM-1],
    output logic                        valid_out,
    output logic [EXP_WIDTH-1:0]        exp_out
);

    localparam int unsigned CNT_W = (BLK_CYC > 1) ? $clog2(BLK_CYC) : 1;
    localparam int unsigned SHIFT = IN_WIDTH - OUT_WIDTH;
    localparam int unsigned NPATH = 4;
    localparam logic [EXP_WIDTH-1:0]   RSB_MAX  = EXP_WIDTH'(IN_WIDTH - 1);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(BLK_CYC - 1);
    localparam logic signed [IN_WIDTH:0] RND     = (IN_WIDTH+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = -SAT_MAX - (IN_WIDTH+1)'(1);

    typedef enum logic {S_IDLE, S_OUT} state_t;

    // Count of bits below the MSB that replicate it.
    function automatic logic [EXP_WIDTH-1:0] rsb(input logic [IN_WIDTH-1:0] x);
        logic [EXP_WIDTH-1:0] n;
        logic                 run;
        n   = '0;
        run = 1'b1;
        for (int i = int'(IN_WIDTH) - 2; i >= 0; i--) begin
            if (run && (x[i] == x[IN_WIDTH-1])) n = n + EXP_WIDTH'(1);
            else                                run = 1'b0;
        end
        return n;
    endfunction

    // Shift by the block exponent, round half-up, saturate to the output width.
    function automatic logic signed [OUT_WIDTH-1:0] norm(input logic signed [IN_WIDTH-1:0] x,
                                                         input logic [EXP_WIDTH-1:0]      e);
        logic signed [IN_WIDTH-1:0]  s;
        logic signed [IN_WIDTH:0]    r;
        logic signed [OUT_WIDTH-1:0] o;
        s = x <<< e;
        r = ($signed({s[IN_WIDTH-1], s}) + RND) >>> SHIFT;
        if (r > SAT_MAX)      o = OUT_WIDTH'(SAT_MAX);
        else if (r < SAT_MIN) o = OUT_WIDTH'(SAT_MIN);
        else                  o = OUT_WIDTH'(r);
        return o;
    endfunction

    logic signed [IN_WIDTH-1:0]  din_all_c [NPATH][NUM];
    logic [EXP_WIDTH-1:0]        rsb_c     [NPATH][NUM];
    logic [EXP_WIDTH-1:0]        beat_min_c, run_min_c;
    logic signed [IN_WIDTH-1:0]  mem_q     [2][BLK_CYC][NPATH][NUM];
    logic signed [OUT_WIDTH-1:0] norm_c    [NPATH][NUM];
    logic signed [OUT_WIDTH-1:0] dout_q    [NPATH][NUM];
    logic [CNT_W-1:0]            wr_cnt_q, rd_cnt_q, rd_cnt_d;
    logic                        wr_bank_q, rd_bank_q, rd_bank_d;
    logic [EXP_WIDTH-1:0]        min_q, exp_out_q;
    logic [EXP_WIDTH-1:0]        exp_bank_q [2];
    logic [1:0]                  pending_q, pending_d, set_c, pend_c, clr_c;
    logic                        blk_done_c, valid_out_q;
    state_t                      state_q, state_d;

    // Gather the four paths and their sign-bit counts.
    always_comb begin
        for (int l = 0; l < int'(NUM); l++) begin
            din_all_c[0][l] = din1_re[l];
            din_all_c[1][l] = din1_im[l];
            din_all_c[2][l] = din2_re[l];
            din_all_c[3][l] = din2_im[l];
        end
        for (int p = 0; p < int'(NPATH); p++)
            for (int l = 0; l < int'(NUM); l++)
                rsb_c[p][l] = rsb(din_all_c[p][l]);
    end

    // Minimum over this beat, merged into the running block minimum.
    always_comb begin
        beat_min_c = RSB_MAX;
        for (int p = 0; p < int'(NPATH); p++)
            for (int l = 0; l < int'(NUM); l++)
                if (rsb_c[p][l] < beat_min_c) beat_min_c = rsb_c[p][l];
        if (wr_cnt_q == '0)            run_min_c = beat_min_c;
        else if (beat_min_c < min_q)   run_min_c = beat_min_c;
        else                           run_min_c = min_q;
        blk_done_c = valid_in && (wr_cnt_q == CNT_LAST);
        set_c      = blk_done_c ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
    end

    // Sample storage; contents need no reset since reads follow a full write.
    always_ff @(posedge clk) begin
        if (valid_in) mem_q[wr_bank_q][wr_cnt_q] <= din_all_c;
    end

    // Write-side counters, block exponent latch and pending flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q      <= '0;
            wr_bank_q     <= 1'b0;
            min_q         <= '0;
            exp_bank_q[0] <= '0;
            exp_bank_q[1] <= '0;
            pending_q     <= '0;
        end else begin
            pending_q <= pending_d;
            if (valid_in) begin
                min_q <= run_min_c;
                if (blk_done_c) begin
                    wr_cnt_q              <= '0;
                    wr_bank_q             <= ~wr_bank_q;
                    exp_bank_q[wr_bank_q] <= run_min_c;
                end else begin
                    wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Read FSM next state; a block finishing this cycle counts as pending.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        clr_c     = 2'b00;
        pend_c    = pending_q | set_c;
        case (state_q)
            S_IDLE: begin
                rd_cnt_d = '0;
                if (pend_c[rd_bank_q]) state_d = S_OUT;
            end
            S_OUT: begin
                if (rd_cnt_q == CNT_LAST) begin
                    clr_c[rd_bank_q] = 1'b1;
                    rd_bank_d        = ~rd_bank_q;
                    rd_cnt_d         = '0;
                    state_d          = pend_c[~rd_bank_q] ? S_OUT : S_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        pending_d = pend_c & ~clr_c;
    end

    // Normalise the slot being read.
    always_comb begin
        for (int p = 0; p < int'(NPATH); p++)
            for (int l = 0; l < int'(NUM); l++)
                norm_c[p][l] = norm(mem_q[rd_bank_q][rd_cnt_q][p][l], exp_bank_q[rd_bank_q]);
    end

    // Output registers; data and exponent hold while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out_q <= 1'b0;
            exp_out_q   <= '0;
            for (int p = 0; p < int'(NPATH); p++)
                for (int l = 0; l < int'(NUM); l++)
                    dout_q[p][l] <= '0;
        end else if (state_q == S_OUT) begin
            valid_out_q <= 1'b1;
            exp_out_q   <= exp_bank_q[rd_bank_q];
            dout_q      <= norm_c;
        end else begin
            valid_out_q <= 1'b0;
        end
    end

    // Port mapping of the output registers.
    always_comb begin
        for (int l = 0; l < int'(NUM); l++) begin
            dout1_re[l] = dout_q[0][l];
            dout1_im[l] = dout_q[1][l];
            dout2_re[l] = dout_q[2][l];
            dout2_im[l] = dout_q[3][l];
        end
        valid_out = valid_out_q;
        exp_out   = exp_out_q;
    end

endmodule

// File: tb/tb_cbfp_scaler.sv
// Directed self-checking bench for cbfp_scaler.
module tb_cbfp_scaler;

    localparam int IW = 23;
    localparam int OW = 11;
    localparam int N  = 16;
    localparam int EW = 5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic valid_in = 1'b0;
    logic signed [IW-1:0] din1_re [0:N-1];
    logic signed [IW-1:0] din1_im [0:N-1];
    logic signed [IW-1:0] din2_re [0:N-1];
    logic signed [IW-1:0] din2_im [0:N-1];
    logic signed [OW-1:0] dout1_re [0:N-1];
    logic signed [OW-1:0] dout1_im [0:N-1];
    logic signed [OW-1:0] dout2_re [0:N-1];
    logic signed [OW-1:0] dout2_im [0:N-1];
    logic                 valid_out;
    logic [EW-1:0]        exp_out;

    int errors = 0;
    int checks = 0;

    logic signed [IW-1:0] blk  [0:7][0:3][0:N-1];
    logic signed [OW-1:0] expd [0:7][0:3][0:N-1];
    logic [EW-1:0]        expe [0:7];
    logic signed [OW-1:0] cap  [0:63][0:3][0:N-1];
    logic [EW-1:0]        cap_exp [0:63];
    int cap_cyc [0:63];
    int in_cyc  [0:63];
    int cap_n = 0;
    int in_n  = 0;
    int ncyc  = 0;

    cbfp_scaler dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
        .dout1_re(dout1_re), .dout1_im(dout1_im), .dout2_re(dout2_re), .dout2_im(dout2_im),
        .valid_out(valid_out), .exp_out(exp_out)
    );

    always #5 clk = ~clk;

    function automatic logic signed [OW-1:0] get_out(input int p, input int l);
        case (p)
            0:       return dout1_re[l];
            1:       return dout1_im[l];
            2:       return dout2_re[l];
            default: return dout2_im[l];
        endcase
    endfunction

    // Record input and output beats at the falling edge.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (valid_in && in_n < 64) begin
            in_cyc[in_n] = ncyc;
            in_n = in_n + 1;
        end
        if (valid_out && cap_n < 64) begin
            cap_exp[cap_n] = exp_out;
            cap_cyc[cap_n] = ncyc;
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    cap[cap_n][p][l] = get_out(p, l);
            cap_n = cap_n + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic fill(input int b0, input int nb, input logic signed [IW-1:0] v);
        for (int b = b0; b < b0 + nb; b++)
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    blk[b][p][l] = v;
    endtask

    task automatic want(input int b0, input int nb, input logic signed [OW-1:0] v, input logic [EW-1:0] e);
        for (int b = b0; b < b0 + nb; b++) begin
            expe[b] = e;
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    expd[b][p][l] = v;
        end
    endtask

    task automatic send(input int first, input int cnt, input int gap);
        for (int b = 0; b < cnt; b++) begin
            valid_in = 1'b1;
            for (int l = 0; l < N; l++) begin
                din1_re[l] = blk[first+b][0][l];
                din1_im[l] = blk[first+b][1][l];
                din2_re[l] = blk[first+b][2][l];
                din2_im[l] = blk[first+b][3][l];
            end
            @(posedge clk); #1;
            valid_in = 1'b0;
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        idle(2);
        for (int p = 0; p < 4; p++)
            for (int l = 0; l < N; l++)
                if (get_out(p, l) !== '0) bad++;
        checks++;
        if (valid_out !== 1'b0 || exp_out !== '0 || bad != 0) begin
            errors++;
            $display("FAIL reset: valid_out=%b exp_out=%0d nonzero_dout=%0d, want 0/0/0", valid_out, exp_out, bad);
        end
    endtask

    task automatic test_ones();
        int cb, ib, bad;
        logic signed [OW-1:0] fa, fe;
        cb = cap_n; ib = in_n;
        fill(0, 4, 23'sd1);  blk[2][1][5] = '0;
        want(0, 4, 11'sd512, 5'd21); expd[2][1][5] = '0;
        send(0, 4, 0);
        idle(12);
        checks++;
        if (cap_n - cb != 4) begin errors++; $display("FAIL ones_count: got %0d beats, want 4", cap_n - cb); end
        checks++;
        if (cap_cyc[cb] - in_cyc[ib] != 5) begin errors++; $display("FAIL ones_latency: got %0d, want 5", cap_cyc[cb] - in_cyc[ib]); end
        checks++;
        if (cap_cyc[cb+3] - cap_cyc[cb] != 3) begin errors++; $display("FAIL ones_contig: span %0d, want 3", cap_cyc[cb+3] - cap_cyc[cb]); end
        for (int b = 0; b < 4; b++) begin
            bad = 0; fa = '0; fe = '0;
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    if (cap[cb+b][p][l] !== expd[b][p][l]) begin
                        if (bad == 0) begin fa = cap[cb+b][p][l]; fe = expd[b][p][l]; end
                        bad++;
                    end
            checks++;
            if (bad != 0 || cap_exp[cb+b] !== expe[b]) begin
                errors++;
                $display("FAIL ones_beat%0d: exp=%0d want %0d, %0d bad lanes, first got %0d want %0d", b, cap_exp[cb+b], expe[b], bad, fa, fe);
            end
        end
        checks++;
        if (valid_out !== 1'b0 || exp_out !== 5'd21) begin
            errors++; $display("FAIL ones_hold: valid_out=%b exp_out=%0d, want 0/21", valid_out, exp_out);
        end
    endtask

    task automatic test_neg_full();
        int cb, bad;
        logic signed [OW-1:0] fa, fe;
        cb = cap_n;
        fill(0, 4, 23'sd4096); blk[0][0][0] = 23'h400000;
        want(0, 4, 11'sd1, 5'd0); expd[0][0][0] = 11'h400;
        send(0, 4, 0);
        idle(12);
        checks++;
        if (cap_n - cb != 4) begin errors++; $display("FAIL neg_count: got %0d beats, want 4", cap_n - cb); end
        for (int b = 0; b < 4; b++) begin
            bad = 0; fa = '0; fe = '0;
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    if (cap[cb+b][p][l] !== expd[b][p][l]) begin
                        if (bad == 0) begin fa = cap[cb+b][p][l]; fe = expd[b][p][l]; end
                        bad++;
                    end
            checks++;
            if (bad != 0 || cap_exp[cb+b] !== expe[b]) begin
                errors++;
                $display("FAIL neg_beat%0d: exp=%0d want %0d, %0d bad lanes, first got %0d want %0d", b, cap_exp[cb+b], expe[b], bad, fa, fe);
            end
        end
    endtask

    task automatic test_sat_and_zero();
        int cb, bad;
        logic signed [OW-1:0] fa, fe;
        cb = cap_n;
        fill(0, 4, '0); blk[3][3][15] = 23'h3FFFFF;
        want(0, 4, '0, 5'd0); expd[3][3][15] = 11'sd1023;
        fill(4, 4, '0);
        want(4, 4, '0, 5'd22);
        send(0, 4, 0);
        idle(10);
        send(4, 4, 0);
        idle(12);
        checks++;
        if (cap_n - cb != 8) begin errors++; $display("FAIL satzero_count: got %0d beats, want 8", cap_n - cb); end
        for (int b = 0; b < 8; b++) begin
            bad = 0; fa = '0; fe = '0;
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    if (cap[cb+b][p][l] !== expd[b][p][l]) begin
                        if (bad == 0) begin fa = cap[cb+b][p][l]; fe = expd[b][p][l]; end
                        bad++;
                    end
            checks++;
            if (bad != 0 || cap_exp[cb+b] !== expe[b]) begin
                errors++;
                $display("FAIL satzero_beat%0d: exp=%0d want %0d, %0d bad lanes, first got %0d want %0d", b, cap_exp[cb+b], expe[b], bad, fa, fe);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cb, bad;
        logic signed [OW-1:0] fa, fe;
        cb = cap_n;
        fill(0, 8, '0);
        blk[1][2][3] = 23'h100000; blk[0][0][0] = -23'sd5000;
        blk[6][0][7] = 23'sd1024;  blk[5][3][0] = -23'sd3;
        want(0, 4, '0, 5'd1);  expd[1][2][3] = 11'sd512; expd[0][0][0] = -11'sd2;
        want(4, 4, '0, 5'd11); expd[6][0][7] = 11'sd512; expd[5][3][0] = -11'sd1;
        send(0, 8, 0);
        idle(14);
        checks++;
        if (cap_n - cb != 8) begin errors++; $display("FAIL b2b_count: got %0d beats, want 8", cap_n - cb); end
        checks++;
        if (cap_cyc[cb+7] - cap_cyc[cb] != 7) begin errors++; $display("FAIL b2b_contig: span %0d, want 7", cap_cyc[cb+7] - cap_cyc[cb]); end
        for (int b = 0; b < 8; b++) begin
            bad = 0; fa = '0; fe = '0;
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    if (cap[cb+b][p][l] !== expd[b][p][l]) begin
                        if (bad == 0) begin fa = cap[cb+b][p][l]; fe = expd[b][p][l]; end
                        bad++;
                    end
            checks++;
            if (bad != 0 || cap_exp[cb+b] !== expe[b]) begin
                errors++;
                $display("FAIL b2b_beat%0d: exp=%0d want %0d, %0d bad lanes, first got %0d want %0d", b, cap_exp[cb+b], expe[b], bad, fa, fe);
            end
        end
    endtask

    task automatic test_gaps();
        int cb, ib, bad;
        logic signed [OW-1:0] fa, fe;
        cb = cap_n; ib = in_n;
        fill(0, 4, 23'sd1);  blk[2][1][5] = '0;
        want(0, 4, 11'sd512, 5'd21); expd[2][1][5] = '0;
        fill(4, 4, 23'sd1024);
        want(4, 4, 11'sd512, 5'd11);
        send(0, 4, 2);
        idle(3);
        send(4, 4, 0);
        idle(5);
        send(4, 4, 0);
        want(8 - 8, 0, '0, '0);
        idle(14);
        checks++;
        if (cap_n - cb != 12) begin errors++; $display("FAIL gaps_count: got %0d beats, want 12", cap_n - cb); end
        checks++;
        if (cap_cyc[cb] - in_cyc[ib+3] != 2) begin errors++; $display("FAIL gaps_latency: got %0d, want 2", cap_cyc[cb] - in_cyc[ib+3]); end
        checks++;
        if (cap_cyc[cb+3] - cap_cyc[cb] != 3) begin errors++; $display("FAIL gaps_contig: span %0d, want 3", cap_cyc[cb+3] - cap_cyc[cb]); end
        for (int b = 0; b < 12; b++) begin
            bad = 0; fa = '0; fe = '0;
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    if (cap[cb+b][p][l] !== expd[(b < 8) ? b : b - 4][p][l]) begin
                        if (bad == 0) begin fa = cap[cb+b][p][l]; fe = expd[(b < 8) ? b : b - 4][p][l]; end
                        bad++;
                    end
            checks++;
            if (bad != 0 || cap_exp[cb+b] !== expe[(b < 8) ? b : b - 4]) begin
                errors++;
                $display("FAIL gaps_beat%0d: exp=%0d want %0d, %0d bad lanes, first got %0d want %0d", b, cap_exp[cb+b], expe[(b < 8) ? b : b - 4], bad, fa, fe);
            end
        end
    endtask

    task automatic test_mid_reset();
        int cb, bad;
        logic signed [OW-1:0] fa, fe;
        cb = cap_n;
        fill(0, 2, 23'h400000);
        send(0, 2, 0);
        rstn = 1'b0;
        idle(2);
        checks++;
        if (valid_out !== 1'b0 || exp_out !== '0 || dout1_re[0] !== '0) begin
            errors++;
            $display("FAIL rst_state: valid_out=%b exp_out=%0d dout1_re0=%0d, want 0/0/0", valid_out, exp_out, dout1_re[0]);
        end
        rstn = 1'b1;
        idle(10);
        checks++;
        if (cap_n != cb) begin errors++; $display("FAIL rst_no_output: got %0d beats, want 0", cap_n - cb); end
        fill(0, 4, 23'sd1024);
        want(0, 4, 11'sd512, 5'd11);
        send(0, 4, 0);
        idle(12);
        checks++;
        if (cap_n - cb != 4) begin errors++; $display("FAIL rst_count: got %0d beats, want 4", cap_n - cb); end
        for (int b = 0; b < 4; b++) begin
            bad = 0; fa = '0; fe = '0;
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < N; l++)
                    if (cap[cb+b][p][l] !== expd[b][p][l]) begin
                        if (bad == 0) begin fa = cap[cb+b][p][l]; fe = expd[b][p][l]; end
                        bad++;
                    end
            checks++;
            if (bad != 0 || cap_exp[cb+b] !== expe[b]) begin
                errors++;
                $display("FAIL rst_beat%0d: exp=%0d want %0d, %0d bad lanes, first got %0d want %0d", b, cap_exp[cb+b], expe[b], bad, fa, fe);
            end
        end
    endtask

    initial begin
        for (int l = 0; l < N; l++) begin
            din1_re[l] = '0; din1_im[l] = '0; din2_re[l] = '0; din2_im[l] = '0;
        end
        #1;
        test_reset();
        rstn = 1'b1;
        idle(2);
        test_ones();
        test_neg_full();
        test_sat_and_zero();
        test_back_to_back();
        test_gaps();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
